// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode handshake.
// master = fetch stage side, slave = memory + decode side.
interface fetch_stage_if #(
  parameter int WORD_SIZE = 32
);
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [WORD_SIZE-1:0] imem_req_addr;
  logic                 imem_resp_valid;
  logic [WORD_SIZE-1:0] imem_resp_data;
  logic [WORD_SIZE-1:0] instruction;
  logic [WORD_SIZE-1:0] instruction_pc;
  logic                 instruction_valid;
  logic                 instruction_ready;

  modport master (
    output imem_req_valid, imem_req_addr, instruction, instruction_pc, instruction_valid,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instruction_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instruction, instruction_pc, instruction_valid,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instruction_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited in-order requests, buffers
// responses in a small FIFO for decode, and flushes on redirect.
module fetch_stage #(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  fetch_stage_if.master        bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

  logic [WORD_SIZE-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outst_q, outst_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WORD_SIZE-1:0] data_mem [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] pc_mem   [FIFO_DEPTH];

  logic                 req_valid, accept, resp, push, pop, instr_valid;
  logic [WORD_SIZE-1:0] target;

  assign target = {redirect_pc[WORD_SIZE-1:2], 2'b00};

  // Credit rule: in-flight plus buffered never exceeds the FIFO, so a push always fits.
  always_comb begin
    req_valid   = !reset && !redirect_valid &&
                  (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_W);
    accept      = req_valid && bus.imem_req_ready;
    resp        = bus.imem_resp_valid;
    push        = resp && !redirect_valid && (drop_q == '0);
    instr_valid = !reset && !redirect_valid && (count_q != '0);
    pop         = instr_valid && bus.instruction_ready;
  end

  assign bus.imem_req_valid    = req_valid;
  assign bus.imem_req_addr     = pc_q;
  assign bus.instruction_valid = instr_valid;
  assign bus.instruction       = data_mem[rptr_q];
  assign bus.instruction_pc    = pc_mem[rptr_q];

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CW'(accept) - CW'(resp);
    drop_d    = drop_q;
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (redirect_valid) begin
      // Everything still in flight (including already-pending drops) must be discarded.
      pc_d      = target;
      resp_pc_d = target;
      count_d   = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      drop_d    = outst_q - CW'(resp);
    end else begin
      if (accept) pc_d = pc_q + WORD_SIZE'(4);
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + WORD_SIZE'(4);
        wptr_d    = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wptr_q] <= bus.imem_resp_data;
      pc_mem[wptr_q]   <= resp_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) assert (count_q != FULL_C);
  end
endmodule
